// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - toggle-handshake SDRAM port bundle (master = arbiter, slave = memory)
//   mem_req  master->slave  request toggle
//   mem_ack  slave->master  acknowledge toggle (memory clock domain)
//   mem_a    master->slave  byte address
//   mem_we   master->slave  1 = write
//   mem_ds   master->slave  byte enables
//   mem_d    master->slave  write data
//   mem_q    slave->master  read data
interface sdram_port_arbiter_if;
    logic        mem_req;
    logic        mem_ack;
    logic [24:0] mem_a;
    logic        mem_we;
    logic [1:0]  mem_ds;
    logic [15:0] mem_d;
    logic [15:0] mem_q;

    modport master (
        output mem_req, mem_a, mem_we, mem_ds, mem_d,
        input  mem_ack, mem_q
    );

    modport slave (
        input  mem_req, mem_a, mem_we, mem_ds, mem_d,
        output mem_ack, mem_q
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares one toggle-handshake SDRAM port between the CPU RAM bus and the ioctl download
//   clk_24, reset       clock, synchronous active-high reset
//   cpu_ad/d/cs/oe/we   CPU RAM bus (level strobes), cpu_q read data, cpu_busy access pending/in flight
//   dl_active/wr/addr/data  download byte stream, dl_overflow sticky drop flag
//   mem                 SDRAM port (master side), acknowledge arrives from the memory clock domain
module sdram_port_arbiter #(
    parameter logic [24:0] DL_BASE  = 25'h0010000,
    parameter int          ACK_SYNC = 2
) (
    input  logic                 clk_24,
    input  logic                 reset,
    input  logic [15:0]          cpu_ad,
    input  logic [7:0]           cpu_d,
    input  logic                 cpu_cs,
    input  logic                 cpu_oe,
    input  logic                 cpu_we,
    output logic [7:0]           cpu_q,
    output logic                 cpu_busy,
    input  logic                 dl_active,
    input  logic                 dl_wr,
    input  logic [24:0]          dl_addr,
    input  logic [7:0]           dl_data,
    output logic                 dl_overflow,
    sdram_port_arbiter_if.master mem
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t state;

    // ack synchronizer; deliberately not reset so mem_req can be realigned to it during reset
    logic [ACK_SYNC-1:0] ack_sync;
    logic                ack_s;

    always_ff @(posedge clk_24) begin
        ack_sync <= {ack_sync[ACK_SYNC-2:0], mem.mem_ack};
    end

    assign ack_s = ack_sync[ACK_SYNC-1];

    // registered port outputs
    logic        mem_req_r;
    logic [24:0] mem_a_r;
    logic        mem_we_r;
    logic [1:0]  mem_ds_r;
    logic [15:0] mem_d_r;

    assign mem.mem_req = mem_req_r;
    assign mem.mem_a   = mem_a_r;
    assign mem.mem_we  = mem_we_r;
    assign mem.mem_ds  = mem_ds_r;
    assign mem.mem_d   = mem_d_r;

    // CPU start detection
    logic        rd_prev, wr_prev, dl_wr_prev;
    logic [15:0] ad_prev;
    logic        rd_lvl, wr_lvl, cpu_start;

    assign rd_lvl    = cpu_cs & cpu_oe;
    assign wr_lvl    = cpu_cs & cpu_we;
    assign cpu_start = (rd_lvl & ~rd_prev) | (wr_lvl & ~wr_prev) |
                       (rd_lvl & rd_prev & (cpu_ad != ad_prev));

    // CPU pending slot (single entry, last start wins until it is granted)
    logic        cpu_pend, cpu_infl;
    logic [15:0] cpu_pa;
    logic [7:0]  cpu_pd;
    logic        cpu_pwe;

    // download FIFO, two entries
    logic [24:0] fifo_addr [2];
    logic [7:0]  fifo_data [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  fifo_count;
    logic        dl_push_req, push_ok, dl_pop;
    logic [24:0] head_addr;
    logic [7:0]  head_data;

    assign dl_push_req = dl_wr & ~dl_wr_prev & dl_active;
    assign push_ok     = dl_push_req & (fifo_count != 2'd2);
    assign head_addr   = fifo_addr[rd_ptr];
    assign head_data   = fifo_data[rd_ptr];

    // arbitration
    logic port_idle, owner_dl, addr0;
    logic grant_cpu, grant_dl, cpu_done;

    assign port_idle = (ack_s == mem_req_r);
    // a full FIFO wins one grant over a pending CPU access so downloads cannot be starved
    assign grant_cpu = (state == S_IDLE) & port_idle & cpu_pend & (fifo_count != 2'd2);
    assign grant_dl  = (state == S_IDLE) & port_idle & ~grant_cpu & (fifo_count != 2'd0);
    assign cpu_done  = (state == S_WAIT) & port_idle & ~owner_dl;
    assign dl_pop    = (state == S_WAIT) & port_idle & owner_dl;

    function automatic logic [1:0] write_ds(input logic a0);
        return a0 ? 2'b10 : 2'b01;
    endfunction

    always_ff @(posedge clk_24) begin
        if (reset) begin
            // realign to the synchronized ack: any in-flight access is abandoned silently
            mem_req_r   <= ack_s;
            mem_a_r     <= '0;
            mem_we_r    <= 1'b0;
            mem_ds_r    <= 2'b11;
            mem_d_r     <= '0;
            cpu_q       <= '0;
            cpu_busy    <= 1'b0;
            dl_overflow <= 1'b0;
            state       <= S_IDLE;
            owner_dl    <= 1'b0;
            addr0       <= 1'b0;
            rd_prev     <= 1'b0;
            wr_prev     <= 1'b0;
            dl_wr_prev  <= 1'b0;
            ad_prev     <= '0;
            cpu_pend    <= 1'b0;
            cpu_infl    <= 1'b0;
            cpu_pa      <= '0;
            cpu_pd      <= '0;
            cpu_pwe     <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= '0;
        end else begin
            rd_prev    <= rd_lvl;
            wr_prev    <= wr_lvl;
            dl_wr_prev <= dl_wr;
            ad_prev    <= cpu_ad;

            // download FIFO
            if (push_ok) begin
                fifo_addr[wr_ptr] <= dl_addr + DL_BASE;
                fifo_data[wr_ptr] <= dl_data;
                wr_ptr            <= ~wr_ptr;
            end else if (dl_push_req) begin
                dl_overflow <= 1'b1;
            end
            if (dl_pop)
                rd_ptr <= ~rd_ptr;
            case ({push_ok, dl_pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase

            case (state)
                S_IDLE: begin
                    if (grant_cpu) begin
                        mem_a_r  <= {9'b0, cpu_pa};
                        mem_we_r <= cpu_pwe;
                        mem_ds_r <= cpu_pwe ? write_ds(cpu_pa[0]) : 2'b11;
                        mem_d_r  <= {cpu_pd, cpu_pd};
                        owner_dl <= 1'b0;
                        addr0    <= cpu_pa[0];
                        cpu_pend <= 1'b0;
                        cpu_infl <= 1'b1;
                        state    <= S_ISSUE;
                    end else if (grant_dl) begin
                        mem_a_r  <= head_addr;
                        mem_we_r <= 1'b1;
                        mem_ds_r <= write_ds(head_addr[0]);
                        mem_d_r  <= {head_data, head_data};
                        owner_dl <= 1'b1;
                        addr0    <= head_addr[0];
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // address/data were loaded a cycle earlier, so they are stable before the toggle
                    mem_req_r <= ~mem_req_r;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (port_idle) begin
                        if (!owner_dl) begin
                            if (!mem_we_r)
                                cpu_q <= addr0 ? mem.mem_q[15:8] : mem.mem_q[7:0];
                            cpu_infl <= 1'b0;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // placed after the FSM so a start in the grant cycle refills the slot
            if (cpu_start) begin
                cpu_pend <= 1'b1;
                cpu_pa   <= cpu_ad;
                cpu_pd   <= cpu_d;
                cpu_pwe  <= cpu_we;
            end

            cpu_busy <= cpu_start | cpu_pend | (cpu_infl & ~cpu_done);
        end
    end

endmodule
